ring_osc_freq_meter: RTL

//  Measures the frequency of a divided ring-oscillator output, such as the div4 tap behind the clock selector.

---
 rtl/ring_osc_freq_meter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ring_osc_freq_meter.sv
// Gated rising-edge counter for a divided ring oscillator, result held for readout.
// Define FREQ_METER_SHIFT_EN to add a serial shift-out of the result (rd_shift/rd_bit).
module ring_osc_freq_meter #(
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              osc_in,
  input  logic              start,
  input  logic              abort,
  input  logic [GATE_W-1:0] gate_len,
`ifdef FREQ_METER_SHIFT_EN
  input  logic              rd_shift,
  output logic              rd_bit,
`endif
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_GATE,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_s;
  logic                   w_edge;
  logic [GATE_W-1:0]      r_gate_cnt;
  logic [GATE_W-1:0]      w_gate_nxt;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_ovf;
  logic                   w_ovf_nxt;
  logic                   r_busy;
  logic                   r_done;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_edge = w_s & ~r_prev;

  // prev follows s every cycle, so the ARM cycle already primes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], osc_in};
      r_prev <= w_s;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_ARM;
      S_ARM: begin
        if (gate_len == '0) w_next = S_DONE;
        else                w_next = S_GATE;
      end
      S_GATE: if (r_gate_cnt == GATE_ONE) w_next = S_DONE;
      S_DONE: if (start) w_next = S_ARM;
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_comb begin
    w_gate_nxt = r_gate_cnt;
    w_cnt_nxt  = r_count;
    w_ovf_nxt  = r_ovf;
    case (r_state)
      S_ARM: begin
        w_gate_nxt = gate_len;
        w_cnt_nxt  = '0;
        w_ovf_nxt  = 1'b0;
      end
      S_GATE: begin
        w_gate_nxt = r_gate_cnt - GATE_ONE;
        if (w_edge) begin
          if (&r_count) w_ovf_nxt = 1'b1;
          else          w_cnt_nxt = r_count + CNT_ONE;
        end
      end
      default: ;
    endcase
    if (abort) begin
      w_cnt_nxt = '0;
      w_ovf_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gate_cnt <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_gate_cnt <= w_gate_nxt;
      r_count    <= w_cnt_nxt;
      r_ovf      <= w_ovf_nxt;
      r_busy     <= (w_next == S_ARM) || (w_next == S_GATE);
      r_done     <= (w_next == S_DONE);
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign count    = r_count;
  assign overflow = r_ovf;

`ifdef FREQ_METER_SHIFT_EN
  logic [CNT_W-1:0] r_shadow;

  // load uses the next count so the final gate edge is included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (w_next == S_DONE && r_state != S_DONE) begin
      r_shadow <= w_cnt_nxt;
    end else if (r_state == S_DONE && rd_shift) begin
      r_shadow <= {r_shadow[CNT_W-2:0], 1'b0};
    end
  end

  assign rd_bit = r_shadow[CNT_W-1];
`endif

endmodule
